// File: rtl/maxterm_scanner.sv
// Sweeps all 2^N inputs through an external combinational function, captures its truth table,
// then streams the indices where the function is 0 over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; truth and zero_count hold the last result
// SCAN  | fx = cnt, fs captured into truth[cnt] each edge
// EMIT  | offer ptr as a maxterm when truth[ptr] = 0, otherwise skip it
// DONE  | one-cycle done pulse, start ignored
module maxterm_scanner #(
  parameter  int N = 3,
  localparam int T = 1 << N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] fx,
  input  logic         fs,
  output logic         busy,
  output logic         done,
  output logic [T-1:0] truth,
  output logic [N:0]   zero_count,
  output logic [N-1:0] idx,
  output logic         idx_valid,
  input  logic         idx_ready
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

  localparam logic [N-1:0] LAST    = {N{1'b1}};
  localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   ONE_ZC  = {{N{1'b0}}, 1'b1};

  state_t         state, state_nxt;
  logic [N-1:0]   cnt, ptr;
  logic [T-1:0]   truth_q;
  logic [N:0]     zc_q;
  logic           emit_adv;

  // A skipped entry advances unconditionally; a maxterm advances only on transfer.
  assign emit_adv = truth_q[ptr] | idx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_SCAN;
      S_SCAN: if (cnt == LAST) state_nxt = S_EMIT;
      S_EMIT: if (emit_adv && ptr == LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fx        = '0;
    idx       = '0;
    idx_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_SCAN: begin
        fx   = cnt;
        busy = 1'b1;
      end
      S_EMIT: begin
        idx       = ptr;
        idx_valid = ~truth_q[ptr];
        busy      = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ptr     <= '0;
      truth_q <= '0;
      zc_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt     <= '0;
          truth_q <= '0;
          zc_q    <= '0;
        end
        S_SCAN: begin
          truth_q[cnt] <= fs;
          if (!fs) zc_q <= zc_q + ONE_ZC;
          if (cnt == LAST) ptr <= '0;
          else             cnt <= cnt + ONE_N;
        end
        // ptr wraps to 0 when leaving EMIT, ready for the next scan.
        S_EMIT: if (emit_adv) ptr <= ptr + ONE_N;
        default: ;
      endcase
    end
  end

  assign truth      = truth_q;
  assign zero_count = zc_q;

endmodule

// File: tb/tb_maxterm_scanner.sv
// Bench for maxterm_scanner: N=3 instance checked through idx/done scoreboards,
// plus N=1 and N=4 instances for the parameter sweep.
module tb_maxterm_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // N=3 instance
  logic       start3 = 1'b0, ready3 = 1'b1;
  logic [2:0] fx3, idx3;
  logic       fs3, busy3, done3, v3;
  logic [7:0] truth3, tbl3 = 8'hFF;
  logic [3:0] zc3;
  assign fs3 = tbl3[fx3];

  // N=1 and N=4 instances
  logic        start_s = 1'b0, ready_s = 1'b1;
  logic [0:0]  fx1, idx1;
  logic        fs1, busy1, done1, v1;
  logic [1:0]  truth1, zc1;
  logic [1:0]  tbl1 = 2'b01;
  logic [3:0]  fx4, idx4;
  logic        fs4, busy4, done4, v4;
  logic [15:0] truth4;
  logic [15:0] tbl4 = 16'h7FFE;
  logic [4:0]  zc4;
  assign fs1 = tbl1[fx1];
  assign fs4 = tbl4[fx4];

  maxterm_scanner #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .fx(fx3), .fs(fs3), .busy(busy3),
    .done(done3), .truth(truth3), .zero_count(zc3), .idx(idx3), .idx_valid(v3),
    .idx_ready(ready3));

  maxterm_scanner #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .fx(fx1), .fs(fs1), .busy(busy1),
    .done(done1), .truth(truth1), .zero_count(zc1), .idx(idx1), .idx_valid(v1),
    .idx_ready(ready_s));

  maxterm_scanner #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .fx(fx4), .fs(fs4), .busy(busy4),
    .done(done4), .truth(truth4), .zero_count(zc4), .idx(idx4), .idx_valid(v4),
    .idx_ready(ready_s));

  typedef struct {
    logic [7:0] truth;
    logic [3:0] zc;
    int         cyc;
  } done_t;

  int    q3[$], q1[$], q4[$];
  done_t qd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Backpressure driver: when bp=1, each offer sees 3 low cycles before ready rises.
  logic bp = 1'b0;
  int   wc = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!bp) ready3 = 1'b1;
    else if (v3) begin
      if (wc == 3) begin ready3 = 1'b1; wc = 0; end
      else begin ready3 = 1'b0; wc++; end
    end else begin
      ready3 = 1'b0;
      wc = 0;
    end
  end

  // Monitor for the N=3 instance
  logic       prev_v = 1'b0, prev_fire = 1'b0;
  logic [2:0] prev_idx = '0;
  initial forever begin
    @(negedge clk);
    if (rst_n && prev_v && !prev_fire) begin
      check("hold_valid", v3, 1'b1);
      check("hold_idx", idx3, prev_idx);
    end
    if (v3 && ready3) begin
      xfer++;
      if (q3.size() == 0) unexpected("idx3", idx3);
      else check("idx3", idx3, q3.pop_front());
    end
    if (done3) begin
      if (qd.size() == 0) unexpected("done3", cyc);
      else begin
        done_t e;
        e = qd.pop_front();
        check("truth3", truth3, e.truth);
        check("zero_count3", zc3, e.zc);
        check("done3_cycle", cyc, e.cyc);
      end
    end
    prev_v    = v3 && rst_n;
    prev_fire = v3 && ready3;
    prev_idx  = idx3;
  end

  // Monitor for the N=1 / N=4 instances
  initial forever begin
    @(negedge clk);
    if (v1 && ready_s) begin
      if (q1.size() == 0) unexpected("idx1", idx1);
      else check("idx1", idx1, q1.pop_front());
    end
    if (v4 && ready_s) begin
      if (q4.size() == 0) unexpected("idx4", idx4);
      else check("idx4", idx4, q4.pop_front());
    end
  end

  task automatic push_expect(input logic [7:0] tbl, input int k, input int extra);
    done_t e;
    int z = 0;
    for (int i = 0; i < 8; i++) if (!tbl[i]) begin q3.push_back(i); z++; end
    e.truth = tbl;
    e.zc    = 4'(z);
    e.cyc   = k + 16 + extra;
    qd.push_back(e);
  endtask

  // One scan of the N=3 instance; extra = stall cycles added by backpressure.
  task automatic run3(input logic [7:0] tbl, input int extra);
    int k;
    tbl3 = tbl;
    @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    k = cyc;
    push_expect(tbl, k, extra);
    check("busy_at_start", busy3, 1'b1);
    check("fx_at_start", fx3, 3'd0);
    @(posedge clk);
    #1 check("fx_second", fx3, 3'd1);
    for (int i = 0; i < 200 && qd.size() != 0; i++) @(posedge clk);
    if (qd.size() != 0) begin unexpected("done3_timeout", qd.size()); qd.delete(); end
    check("idx3_leftover", q3.size(), 0);
    q3.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fx"}, fx3, 3'd0);
    check({tag, "_busy"}, busy3, 1'b0);
    check({tag, "_done"}, done3, 1'b0);
    check({tag, "_idx"}, idx3, 3'd0);
    check({tag, "_valid"}, v3, 1'b0);
    check({tag, "_truth"}, truth3, 8'h00);
    check({tag, "_zc"}, zc3, 4'd0);
  endtask

  initial begin
    int k, base, d1, d4;
    #2;
    check_reset_outputs("reset");
    check("reset_truth4", truth4, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // PoS(1,3,6,7), ready always high
    run3(8'b0011_0101, 0);
    // Backpressure: 3 stall cycles on each of 4 maxterms
    bp = 1'b1;
    run3(8'b0011_0101, 12);
    bp = 1'b0;
    // Constants
    run3(8'hFF, 0);
    run3(8'h00, 0);

    // Reset after the second transfer
    tbl3 = 8'b0011_0101;
    @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    k = cyc;
    base = xfer;
    push_expect(tbl3, k, 0);
    for (int i = 0; i < 60 && xfer < base + 2; i++) @(posedge clk);
    if (xfer < base + 2) unexpected("xfer_timeout", xfer - base);
    #3 rst_n = 1'b0;
    q3.delete();
    qd.delete();
    #1 check_reset_outputs("midreset");
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_outputs("after_reset");
    run3(8'b0011_0101, 0);

    // Start held through SCAN/EMIT/DONE: restart only from IDLE
    tbl3 = 8'b0011_0101;
    @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk);
    #1 k = cyc;
    push_expect(tbl3, k, 0);
    push_expect(tbl3, k + 18, 0);
    repeat (16) @(posedge clk);
    #1 check("held_done1", done3, 1'b1);
    @(posedge clk);
    #1 check("held_idle_busy", busy3, 1'b0);
    check("held_idle_done", done3, 1'b0);
    @(posedge clk);
    #1 check("held_restart_busy", busy3, 1'b1);
    repeat (16) @(posedge clk);
    #1 check("held_done2", done3, 1'b1);
    start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("held_no_third", busy3, 1'b0);
    check("held_qd_empty", qd.size(), 0);
    check("held_q3_empty", q3.size(), 0);

    // Parameter sweep: N=1 f=~a, N=4 zeros at 0 and 15
    q1.push_back(1);
    q4.push_back(0);
    q4.push_back(15);
    @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    d1 = 0;
    d4 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done1) d1 = i;
      if (done4) d4 = i;
    end
    check("done1_cycle", d1, 4);
    check("done4_cycle", d4, 32);
    check("truth1", truth1, 2'b01);
    check("zero_count1", zc1, 2'd1);
    check("truth4", truth4, 16'h7FFE);
    check("zero_count4", zc4, 5'd2);
    check("idx1_leftover", q1.size(), 0);
    check("idx4_leftover", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
